// File: rtl/calc_key_sequencer.sv
// Purpose: clocked key sequencer for the keypad calculator; turns decoded keys into operand/ALU/memory strobes.
// Latency: every output is registered; a strobe appears one cycle after its key_valid and lasts one cycle.
// Backpressure: none; keys arriving during EXEC are dropped, ALU completion is awaited under a watchdog.
module calc_key_sequencer #(
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       alu_done,
    input  logic       alu_ovf,
    output logic       dig_a,
    output logic       dig_b,
    output logic       dig_first,
    output logic [3:0] digit,
    output logic       clr_ab,
    output logic       op_sub,
    output logic       alu_start,
    output logic       acc_load,
    output logic       mem_store,
    output logic       mem_recall,
    output logic       recall_dst,
    output logic [1:0] disp_sel,
    output logic       busy,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ENT_A = 3'b001,
        ENT_B = 3'b010,
        OP    = 3'b011,
        RES   = 3'b100,
        EXEC  = 3'b110,
        ERR   = 3'b111
    } state_t;

    localparam int              WW      = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [3:0]      CNT_MAX = 4'(MAX_DIGITS);
    localparam logic [WW-1:0]   WD_LAST = WW'(ALU_TIMEOUT - 1);

    state_t        st_q, st_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          chain_q, chain_d;
    logic          pend_q, pend_d;
    logic [WW-1:0] wd_q, wd_d;

    logic          dig_a_d, dig_b_d, dig_first_d, clr_d, op_sub_d;
    logic          start_d, load_d, store_d, recall_d, rdst_d;
    logic [3:0]    digit_d;

    logic is_dig, is_clr, is_op, is_eq, is_rcl, is_sto, room;

    assign is_dig = (key_code <= 4'd9);
    assign is_clr = (key_code == 4'd10);
    assign is_op  = (key_code == 4'd11) || (key_code == 4'd12);
    assign is_eq  = (key_code == 4'd13);
    assign is_rcl = (key_code == 4'd14);
    assign is_sto = (key_code == 4'd15);
    // Operand still has room for another digit; recall saturates cnt so it also blocks appends.
    assign room   = (cnt_q < CNT_MAX);

    assign state  = st_q;

    // Next-state and next-output decode from current state and key.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        pend_d      = pend_q;
        wd_d        = wd_q;
        dig_a_d     = 1'b0;
        dig_b_d     = 1'b0;
        dig_first_d = 1'b0;
        digit_d     = digit;
        clr_d       = 1'b0;
        op_sub_d    = op_sub;
        start_d     = 1'b0;
        load_d      = 1'b0;
        store_d     = 1'b0;
        recall_d    = 1'b0;
        rdst_d      = recall_dst;

        if (key_valid && is_clr && st_q != EXEC) begin
            clr_d   = 1'b1;
            cnt_d   = 4'd0;
            chain_d = 1'b0;
            st_d    = IDLE;
        end else begin
            case (st_q)
                IDLE, RES: begin
                    if (key_valid) begin
                        if (is_dig) begin
                            dig_a_d     = 1'b1;
                            dig_first_d = 1'b1;
                            digit_d     = key_code;
                            cnt_d       = 4'd1;
                            st_d        = ENT_A;
                        end else if (is_op) begin
                            op_sub_d = (key_code == 4'd11);
                            st_d     = OP;
                        end else if (is_rcl) begin
                            recall_d = 1'b1;
                            rdst_d   = 1'b0;
                            cnt_d    = CNT_MAX;
                            st_d     = ENT_A;
                        end else if (is_sto) begin
                            store_d = 1'b1;
                        end
                    end
                end
                ENT_A: begin
                    if (key_valid) begin
                        if (is_dig) begin
                            if (room) begin
                                dig_a_d = 1'b1;
                                digit_d = key_code;
                                cnt_d   = cnt_q + 4'd1;
                            end
                        end else if (is_op) begin
                            op_sub_d = (key_code == 4'd11);
                            st_d     = OP;
                        end else if (is_sto) begin
                            store_d = 1'b1;
                        end else if (is_rcl) begin
                            recall_d = 1'b1;
                            rdst_d   = 1'b0;
                            cnt_d    = CNT_MAX;
                        end
                    end
                end
                OP: begin
                    if (key_valid) begin
                        if (is_dig) begin
                            dig_b_d     = 1'b1;
                            dig_first_d = 1'b1;
                            digit_d     = key_code;
                            cnt_d       = 4'd1;
                            st_d        = ENT_B;
                        end else if (is_op) begin
                            op_sub_d = (key_code == 4'd11);
                        end else if (is_rcl) begin
                            recall_d = 1'b1;
                            rdst_d   = 1'b1;
                            cnt_d    = CNT_MAX;
                            st_d     = ENT_B;
                        end
                    end
                end
                ENT_B: begin
                    if (key_valid) begin
                        if (is_dig) begin
                            if (room) begin
                                dig_b_d = 1'b1;
                                digit_d = key_code;
                                cnt_d   = cnt_q + 4'd1;
                            end
                        end else if (is_eq || is_op) begin
                            // op_sub stays put while the ALU runs; a chained operator waits in pend.
                            start_d = 1'b1;
                            chain_d = is_op;
                            if (is_op) pend_d = (key_code == 4'd11);
                            wd_d    = '0;
                            st_d    = EXEC;
                        end else if (is_rcl) begin
                            recall_d = 1'b1;
                            rdst_d   = 1'b1;
                            cnt_d    = CNT_MAX;
                        end
                    end
                end
                EXEC: begin
                    // alu_done takes priority over watchdog expiry in the same cycle.
                    if (alu_done) begin
                        load_d = 1'b1;
                        if (alu_ovf) begin
                            st_d = ERR;
                        end else if (chain_q) begin
                            op_sub_d = pend_q;
                            chain_d  = 1'b0;
                            st_d     = OP;
                        end else begin
                            st_d = RES;
                        end
                    end else if (wd_q == WD_LAST) begin
                        st_d = ERR;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, bookkeeping and registered outputs; status outputs track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            cnt_q      <= 4'd0;
            chain_q    <= 1'b0;
            pend_q     <= 1'b0;
            wd_q       <= '0;
            dig_a      <= 1'b0;
            dig_b      <= 1'b0;
            dig_first  <= 1'b0;
            digit      <= 4'd0;
            clr_ab     <= 1'b0;
            op_sub     <= 1'b0;
            alu_start  <= 1'b0;
            acc_load   <= 1'b0;
            mem_store  <= 1'b0;
            mem_recall <= 1'b0;
            recall_dst <= 1'b0;
            disp_sel   <= 2'b00;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            chain_q    <= chain_d;
            pend_q     <= pend_d;
            wd_q       <= wd_d;
            dig_a      <= dig_a_d;
            dig_b      <= dig_b_d;
            dig_first  <= dig_first_d;
            digit      <= digit_d;
            clr_ab     <= clr_d;
            op_sub     <= op_sub_d;
            alu_start  <= start_d;
            acc_load   <= load_d;
            mem_store  <= store_d;
            mem_recall <= recall_d;
            recall_dst <= rdst_d;
            disp_sel   <= (st_d == ENT_B) ? 2'b01 : (st_d == ERR) ? 2'b10 : 2'b00;
            busy       <= (st_d == EXEC);
            err        <= (st_d == ERR);
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Purpose: table-driven bench for calc_key_sequencer with a queue of expected post-edge outputs.
// Latency: each table row covers one clock edge; its expectation is compared #1 after that edge.
// Backpressure: not applicable; stimulus is one row per cycle, queue depth stays at one.
module tb_calc_key_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_ENA = 3'd1, S_ENB = 3'd2, S_OP = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4, S_EX  = 3'd6, S_ERR = 3'd7;
    // strobe vector order: {dig_a, dig_b, clr_ab, alu_start, acc_load, mem_store, mem_recall}
    localparam logic [6:0] N  = 7'b0000000, DA = 7'b1000000, DB = 7'b0100000, CL = 7'b0010000;
    localparam logic [6:0] AS = 7'b0001000, AL = 7'b0000100, MS = 7'b0000010, MR = 7'b0000001;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       ad;
        logic       ao;
        logic [6:0] stb;
        logic [3:0] dg;
        logic       df;
        logic       rd;
        logic       os;
        logic [2:0] st;
        int         tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic alu_done = 1'b0;
    logic alu_ovf = 1'b0;
    logic dig_a, dig_b, dig_first, clr_ab, op_sub, alu_start, acc_load;
    logic mem_store, mem_recall, recall_dst, busy, err;
    logic [3:0] digit;
    logic [1:0] disp_sel;
    logic [2:0] state;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t sb[$];
    vec_t em;

    calc_key_sequencer #(.MAX_DIGITS(4), .ALU_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_done(alu_done), .alu_ovf(alu_ovf), .dig_a(dig_a), .dig_b(dig_b),
        .dig_first(dig_first), .digit(digit), .clr_ab(clr_ab), .op_sub(op_sub),
        .alu_start(alu_start), .acc_load(acc_load), .mem_store(mem_store),
        .mem_recall(mem_recall), .recall_dst(recall_dst), .disp_sel(disp_sel),
        .busy(busy), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic ad, input logic ao,
                                input logic [6:0] stb, input logic [3:0] dg, input logic df,
                                input logic rd, input logic os, input logic [2:0] st, input int tag);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ad = ad; v.ao = ao; v.stb = stb; v.dg = dg;
        v.df = df; v.rd = rd; v.os = os; v.st = st; v.tag = tag;
        return v;
    endfunction

    // key press row
    task automatic K(input logic [3:0] kc, input logic [6:0] stb, input logic [3:0] dg, input logic df,
                     input logic rd, input logic os, input logic [2:0] st);
        tbl.push_back(mk(1'b1, kc, 1'b0, 1'b0, stb, dg, df, rd, os, st, tbl.size()));
    endtask

    // no-key row, optionally with ALU handshake inputs
    task automatic I(input logic ad, input logic ao, input logic [6:0] stb, input logic os, input logic [2:0] st);
        tbl.push_back(mk(1'b0, 4'd0, ad, ao, stb, 4'd0, 1'b0, 1'b0, os, st, tbl.size()));
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        key_valid = v.kv;
        key_code  = v.kc;
        alu_done  = v.ad;
        alu_ovf   = v.ao;
        sb.push_back(v);
    endtask

    task automatic quiet();
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
        alu_done  = 1'b0;
        alu_ovf   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [20:0] all_outs();
        return {dig_a, dig_b, dig_first, digit, clr_ab, op_sub, alu_start, acc_load,
                mem_store, mem_recall, recall_dst, disp_sel, busy, err, state};
    endfunction

    // Compare the oldest expectation against outputs just after the edge it describes.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            em = sb.pop_front();
            chk($sformatf("v%0d.strobes", em.tag),
                32'({dig_a, dig_b, clr_ab, alu_start, acc_load, mem_store, mem_recall}), 32'(em.stb));
            chk($sformatf("v%0d.state", em.tag), 32'(state), 32'(em.st));
            chk($sformatf("v%0d.op_sub", em.tag), 32'(op_sub), 32'(em.os));
            chk($sformatf("v%0d.status", em.tag), 32'({disp_sel, busy, err}),
                32'({(em.st == S_ENB) ? 2'b01 : (em.st == S_ERR) ? 2'b10 : 2'b00,
                     em.st == S_EX, em.st == S_ERR}));
            if (em.stb[6] || em.stb[5]) begin
                chk($sformatf("v%0d.digit", em.tag), 32'(digit), 32'(em.dg));
                chk($sformatf("v%0d.dig_first", em.tag), 32'(dig_first), 32'(em.df));
            end
            if (em.stb[0])
                chk($sformatf("v%0d.recall_dst", em.tag), 32'(recall_dst), 32'(em.rd));
        end
    end

    initial begin
        // basic calculation 12 + 3 =, done two cycles after start, then new calc from RES
        K(1, DA, 1, 1, 0, 0, S_ENA);
        K(2, DA, 2, 0, 0, 0, S_ENA);
        K(12, N, 0, 0, 0, 0, S_OP);
        K(3, DB, 3, 1, 0, 0, S_ENB);
        K(13, AS, 0, 0, 0, 0, S_EX);
        I(0, 0, N, 0, S_EX);
        I(0, 0, N, 0, S_EX);
        I(1, 0, AL, 0, S_RES);
        K(8, DA, 8, 1, 0, 0, S_ENA);
        K(10, CL, 0, 0, 0, 0, S_IDLE);
        // digit limit: six nines, only four accepted
        K(9, DA, 9, 1, 0, 0, S_ENA);
        for (int i = 0; i < 3; i++) K(9, DA, 9, 0, 0, 0, S_ENA);
        K(9, N, 0, 0, 0, 0, S_ENA);
        K(9, N, 0, 0, 0, 0, S_ENA);
        K(10, CL, 0, 0, 0, 0, S_IDLE);
        // chaining 5 - 2 + : op_sub held during EXEC, pending op applied on done
        K(5, DA, 5, 1, 0, 0, S_ENA);
        K(11, N, 0, 0, 0, 1, S_OP);
        K(2, DB, 2, 1, 0, 1, S_ENB);
        K(12, AS, 0, 0, 0, 1, S_EX);
        I(0, 0, N, 1, S_EX);
        I(1, 0, AL, 0, S_OP);
        K(7, DB, 7, 1, 0, 0, S_ENB);
        // watchdog: 16 EXEC cycles, keys (including clear) dropped, then ERR
        K(13, AS, 0, 0, 0, 0, S_EX);
        for (int i = 0; i < 15; i++) K(4'(i), N, 0, 0, 0, 0, S_EX);
        I(0, 0, N, 0, S_ERR);
        K(5, N, 0, 0, 0, 0, S_ERR);
        K(13, N, 0, 0, 0, 0, S_ERR);
        I(1, 1, N, 0, S_ERR);
        K(10, CL, 0, 0, 0, 0, S_IDLE);
        // store / clear / recall to A saturates the digit counter
        K(4, DA, 4, 1, 0, 0, S_ENA);
        K(15, MS, 0, 0, 0, 0, S_ENA);
        K(10, CL, 0, 0, 0, 0, S_IDLE);
        K(14, MR, 0, 0, 0, 0, S_ENA);
        K(5, N, 0, 0, 0, 0, S_ENA);
        K(10, CL, 0, 0, 0, 0, S_IDLE);
        // operator first from IDLE, recall into B
        K(11, N, 0, 0, 0, 1, S_OP);
        K(14, MR, 0, 0, 1, 1, S_ENB);
        K(3, N, 0, 0, 0, 1, S_ENB);
        K(10, CL, 0, 0, 0, 1, S_IDLE);
        // alu_done coinciding with watchdog expiry wins
        K(1, DA, 1, 1, 0, 1, S_ENA);
        K(12, N, 0, 0, 0, 0, S_OP);
        K(2, DB, 2, 1, 0, 0, S_ENB);
        K(13, AS, 0, 0, 0, 0, S_EX);
        for (int i = 0; i < 15; i++) I(0, 0, N, 0, S_EX);
        I(1, 0, AL, 0, S_RES);
        // chain from result, overflow goes to ERR with acc_load
        K(11, N, 0, 0, 0, 1, S_OP);
        K(4, DB, 4, 1, 0, 1, S_ENB);
        K(13, AS, 0, 0, 0, 1, S_EX);
        I(0, 0, N, 1, S_EX);
        I(1, 1, AL, 1, S_ERR);
        K(10, CL, 0, 0, 0, 1, S_IDLE);

        // reset values
        #3;
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        quiet();
        drain();

        // asynchronous reset in the middle of EXEC, then a late alu_done
        step(mk(1'b1, 4'd1, 1'b0, 1'b0, DA, 4'd1, 1'b1, 1'b0, 1'b1, S_ENA, 1000));
        step(mk(1'b1, 4'd11, 1'b0, 1'b0, N, 4'd0, 1'b0, 1'b0, 1'b1, S_OP, 1001));
        step(mk(1'b1, 4'd2, 1'b0, 1'b0, DB, 4'd2, 1'b1, 1'b0, 1'b1, S_ENB, 1002));
        step(mk(1'b1, 4'd13, 1'b0, 1'b0, AS, 4'd0, 1'b0, 1'b0, 1'b1, S_EX, 1003));
        quiet();
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_exec", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1'b0, 4'd0, 1'b1, 1'b1, N, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 1004));
        step(mk(1'b0, 4'd0, 1'b0, 1'b0, N, 4'd0, 1'b0, 1'b0, 1'b0, S_IDLE, 1005));
        quiet();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
